// File: rtl/sawtooth_pkg.sv
// Shared types and constants for the sawtooth voice scheduler: FSM encoding,
// wave LUT latency and the phase/wave/overrun widths.
package sawtooth_pkg;

    localparam int LUT_LAT = 2;
    localparam int PHASE_W = 15;
    localparam int WAVE_W  = 12;
    localparam int OVR_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } sched_state_e;

    // Saturating increment for the dropped-tick counter.
    function automatic logic [OVR_W-1:0] sat_inc(input logic [OVR_W-1:0] v);
        logic [OVR_W-1:0] r;
        r = (v == {OVR_W{1'b1}}) ? v : v + 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/sawtooth_voice_bank.sv
// Per-voice increment, enable and phase accumulator registers with one read
// port (phase, enable) and an advance strobe for the selected voice.
module sawtooth_voice_bank
    import sawtooth_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int ACC_W      = 24,
    localparam int VW        = $clog2(NUM_VOICES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [VW-1:0]      cfg_voice,
    input  logic [ACC_W-1:0]   cfg_inc,
    input  logic               cfg_en,
    input  logic [VW-1:0]      rd_voice,
    input  logic               adv,
    output logic [PHASE_W-1:0] rd_phase,
    output logic               rd_en
);

    logic [ACC_W-1:0] inc_q [NUM_VOICES];
    logic [ACC_W-1:0] inc_d [NUM_VOICES];
    logic [ACC_W-1:0] acc_q [NUM_VOICES];
    logic [ACC_W-1:0] acc_d [NUM_VOICES];
    logic             en_q  [NUM_VOICES];
    logic             en_d  [NUM_VOICES];

    // The advance reads the registered inc/en, so a same-cycle cfg write to
    // the voice being advanced only takes effect from its next issue.
    always_comb begin
        for (int i = 0; i < NUM_VOICES; i++) begin
            inc_d[i] = inc_q[i];
            en_d[i]  = en_q[i];
            acc_d[i] = acc_q[i];
        end
        if (cfg_we) begin
            inc_d[cfg_voice] = cfg_inc;
            en_d[cfg_voice]  = cfg_en;
        end
        if (adv && en_q[rd_voice]) begin
            acc_d[rd_voice] = acc_q[rd_voice] + inc_q[rd_voice];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                inc_q[i] <= '0;
                en_q[i]  <= 1'b0;
                acc_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                inc_q[i] <= inc_d[i];
                en_q[i]  <= en_d[i];
                acc_q[i] <= acc_d[i];
            end
        end
    end

    assign rd_phase = acc_q[rd_voice][ACC_W-1 -: PHASE_W];
    assign rd_en    = en_q[rd_voice];

endmodule

// File: rtl/sawtooth_voice_scheduler.sv
// Time-multiplexes NUM_VOICES sawtooth voices onto one shared wave LUT and sums
// them into one sample per tick. SAWTOOTH_SCHED_OVERRUN_EN adds overrun_cnt.
module sawtooth_voice_scheduler
    import sawtooth_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int ACC_W      = 24,
    localparam int VW        = $clog2(NUM_VOICES),
    localparam int MIX_W     = WAVE_W + VW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sample_tick,
    input  logic               cfg_we,
    input  logic [VW-1:0]      cfg_voice,
    input  logic [ACC_W-1:0]   cfg_inc,
    input  logic               cfg_en,
    output logic [PHASE_W-1:0] phase,
    input  logic [WAVE_W-1:0]  wave,
    output logic [MIX_W-1:0]   mix_data,
    output logic               mix_valid,
    input  logic               mix_ready,
    output logic               busy,
    output sched_state_e       dbg_state
`ifdef SAWTOOTH_SCHED_OVERRUN_EN
    ,
    output logic [OVR_W-1:0]   overrun_cnt
`endif
);

    // Output handshake: mix_valid rises in HOLD and stays high with mix_data
    // frozen until the cycle where mix_valid && mix_ready, which is the one
    // and only transfer of that sample.

    sched_state_e       state_q, state_d;
    logic [VW-1:0]      vcnt_q, vcnt_d;
    logic [1:0]         drain_q, drain_d;
    logic [MIX_W-1:0]   sum_q, sum_d;
    logic [LUT_LAT-1:0] en_pipe_q, en_pipe_d;

    logic               adv;
    logic               issue_en;
    logic [PHASE_W-1:0] rd_phase;
    logic               rd_en;

    sawtooth_voice_bank #(
        .NUM_VOICES (NUM_VOICES),
        .ACC_W      (ACC_W)
    ) u_bank (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_voice (cfg_voice),
        .cfg_inc   (cfg_inc),
        .cfg_en    (cfg_en),
        .rd_voice  (vcnt_q),
        .adv       (adv),
        .rd_phase  (rd_phase),
        .rd_en     (rd_en)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (sample_tick) state_d = ST_ISSUE;
            ST_ISSUE: if (vcnt_q == VW'(NUM_VOICES - 1)) state_d = ST_DRAIN;
            ST_DRAIN: if (drain_q == 2'(LUT_LAT - 1)) state_d = ST_HOLD;
            ST_HOLD:  if (mix_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != ST_IDLE);
        mix_valid = (state_q == ST_HOLD);
        adv       = (state_q == ST_ISSUE);
        issue_en  = adv && rd_en;
        phase     = adv ? rd_phase : '0;
        mix_data  = sum_q;
        dbg_state = state_q;
    end

    // en_pipe tracks which issue slots carry an enabled voice so the wave
    // arriving LUT_LAT cycles later is added only for those.
    always_comb begin
        vcnt_d    = vcnt_q;
        drain_d   = drain_q;
        sum_d     = sum_q;
        en_pipe_d = {en_pipe_q[LUT_LAT-2:0], issue_en};
        if (en_pipe_q[LUT_LAT-1]) begin
            sum_d = sum_q + {{VW{1'b0}}, wave};
        end
        case (state_q)
            ST_IDLE: begin
                if (sample_tick) begin
                    vcnt_d  = '0;
                    drain_d = '0;
                    sum_d   = '0;
                end
            end
            ST_ISSUE: vcnt_d  = vcnt_q + 1'b1;
            ST_DRAIN: drain_d = drain_q + 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vcnt_q    <= '0;
            drain_q   <= '0;
            sum_q     <= '0;
            en_pipe_q <= '0;
        end else begin
            vcnt_q    <= vcnt_d;
            drain_q   <= drain_d;
            sum_q     <= sum_d;
            en_pipe_q <= en_pipe_d;
        end
    end

`ifdef SAWTOOTH_SCHED_OVERRUN_EN
    logic [OVR_W-1:0] overrun_q, overrun_d;

    always_comb begin
        overrun_d = overrun_q;
        if (sample_tick && busy) begin
            overrun_d = sat_inc(overrun_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_q <= '0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun_cnt = overrun_q;
`endif

endmodule

// File: tb/tb_sawtooth_voice_scheduler.sv
// Self-checking bench for sawtooth_voice_scheduler (4 voices, 24-bit acc):
// directed table, hand sequences for corner cases, and randomized frames.
module tb_sawtooth_voice_scheduler;
    import sawtooth_pkg::*;

    localparam int N     = 4;
    localparam int ACC_W = 24;
    localparam int VW    = 2;
    localparam int MIX_W = 14;

    logic               clk = 1'b0;
    logic               rst;
    logic               sample_tick;
    logic               cfg_we;
    logic [VW-1:0]      cfg_voice;
    logic [ACC_W-1:0]   cfg_inc;
    logic               cfg_en;
    logic [14:0]        phase;
    logic [11:0]        wave;
    logic [MIX_W-1:0]   mix_data;
    logic               mix_valid;
    logic               mix_ready;
    logic               busy;
    sched_state_e       dbg_state;
`ifdef SAWTOOTH_SCHED_OVERRUN_EN
    logic [15:0]        overrun_cnt;
`endif

    always #5 clk = ~clk;

    sawtooth_voice_scheduler #(.NUM_VOICES(N), .ACC_W(ACC_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_tick (sample_tick),
        .cfg_we      (cfg_we),
        .cfg_voice   (cfg_voice),
        .cfg_inc     (cfg_inc),
        .cfg_en      (cfg_en),
        .phase       (phase),
        .wave        (wave),
        .mix_data    (mix_data),
        .mix_valid   (mix_valid),
        .mix_ready   (mix_ready),
        .busy        (busy),
        .dbg_state   (dbg_state)
`ifdef SAWTOOTH_SCHED_OVERRUN_EN
        ,
        .overrun_cnt (overrun_cnt)
`endif
    );

    // ---------------- wave LUT model: 2-cycle latency ----------------
    int          wave_mode = 0;
    logic [14:0] ph_d1, ph_d2;

    function automatic logic [11:0] wave_fn(input logic [14:0] ph, input int mode);
        case (mode)
            0:       return ph[14:3];
            1:       return 12'hFFF;
            default: return 12'(int'(ph) * 7 + 13);
        endcase
    endfunction

    always @(posedge clk) begin
        ph_d1 <= phase;
        ph_d2 <= ph_d1;
    end
    always @* wave = wave_fn(ph_d2, wave_mode);

    // ---------------- reference model and scoreboard ----------------
    logic [23:0]      m_acc [N];
    logic [23:0]      m_inc [N];
    logic             m_en  [N];
    int               m_ovr;
    logic [MIX_W-1:0] exp_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int xfer_cnt = 0;

    always @(posedge clk) begin
        if (rst) xfer_cnt <= 0;
        else if (mix_valid && mix_ready) xfer_cnt <= xfer_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_acc[i] = '0;
            m_inc[i] = '0;
            m_en[i]  = 1'b0;
        end
        m_ovr = 0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic cfg_write(input int v, input logic [23:0] inc, input logic en);
        @(negedge clk);
        cfg_we    = 1'b1;
        cfg_voice = VW'(v);
        cfg_inc   = inc;
        cfg_en    = en;
        @(negedge clk);
        cfg_we    = 1'b0;
        m_inc[v]  = inc;
        m_en[v]   = en;
    endtask

    task automatic check_regs_zero(input string tag);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s_acc%0d", tag, i), 32'(dut.u_bank.acc_q[i]), 32'h0);
        end
    endtask

    // One frame: tick, check issued phases, latency and mixed sum.
    // inj_v >= 0 writes cfg to that voice in the same cycle it is issued.
    task automatic run_frame(input int inj_v, input logic [23:0] inj_inc, input logic inj_en,
                             output logic [MIX_W-1:0] got_mix, output logic [14:0] got_ph0);
        logic [14:0]      exp_ph [N];
        logic [MIX_W-1:0] exp_sum;
        logic [MIX_W-1:0] exp_pop;
        int               lat;
        exp_sum = '0;
        for (int v = 0; v < N; v++) begin
            exp_ph[v] = m_acc[v][23:9];
            if (m_en[v]) begin
                exp_sum  = exp_sum + MIX_W'(wave_fn(exp_ph[v], wave_mode));
                m_acc[v] = m_acc[v] + m_inc[v];
            end
        end
        exp_q.push_back(exp_sum);
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        got_ph0 = phase;
        for (int v = 0; v < N; v++) begin
            check($sformatf("issue_phase_v%0d", v), 32'(phase), 32'(exp_ph[v]));
            if (v == inj_v) begin
                cfg_we    = 1'b1;
                cfg_voice = VW'(v);
                cfg_inc   = inj_inc;
                cfg_en    = inj_en;
            end
            @(negedge clk);
            if (v == inj_v) begin
                cfg_we   = 1'b0;
                m_inc[v] = inj_inc;
                m_en[v]  = inj_en;
            end
        end
        check("drain_phase_zero", 32'(phase), 32'h0);
        lat = N + 1;
        while (!mix_valid && lat < N + 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'(N + 3));
        exp_pop = exp_q.pop_front();
        check("mix_data", 32'(mix_data), 32'(exp_pop));
        got_mix = mix_data;
        if (mix_ready) begin
            @(negedge clk);
            check("post_xfer_valid", 32'(mix_valid), 32'h0);
            check("post_xfer_busy", 32'(busy), 32'h0);
        end
    endtask

    typedef struct {
        logic [3:0]       en_mask;
        logic [23:0]      inc0;
        int               mode;
        logic [MIX_W-1:0] exp_mix;
        logic [23:0]      exp_acc0;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [MIX_W-1:0] gm, hold;
        logic [14:0]      gp;
        int               x0;

        vecs[0] = '{4'b0000, 24'h000100, 1, 14'h0000, 24'h000000};
        vecs[1] = '{4'b1111, 24'h000400, 1, 14'h3FFC, 24'h000400};
        vecs[2] = '{4'b0101, 24'h0ABCDE, 1, 14'h1FFE, 24'h0ABCDE};
        vecs[3] = '{4'b0010, 24'h123456, 1, 14'h0FFF, 24'h000000};
        vecs[4] = '{4'b1111, 24'h000010, 2, 14'h0034, 24'h000010};
        vecs[5] = '{4'b1000, 24'h000800, 0, 14'h0000, 24'h000000};

        rst = 1'b1; sample_tick = 1'b0; cfg_we = 1'b0; cfg_voice = '0;
        cfg_inc = '0; cfg_en = 1'b0; mix_ready = 1'b1;
        model_reset();

        // Reset state
        do_reset();
        @(negedge clk);
        check("rst_valid", 32'(mix_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_phase", 32'(phase), 32'h0);
        check("rst_mix", 32'(mix_data), 32'h0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check_regs_zero("rst");
`ifdef SAWTOOTH_SCHED_OVERRUN_EN
        check("rst_overrun", 32'(overrun_cnt), 32'h0);
`endif

        // All voices disabled: zero sum, accumulators untouched
        run_frame(-1, '0, 1'b0, gm, gp);
        check("disabled_mix", 32'(gm), 32'h0);
        check_regs_zero("disabled");

        // Directed single-frame table
        for (int t = 0; t < 6; t++) begin
            do_reset();
            for (int v = 0; v < N; v++) begin
                cfg_write(v, (v == 0) ? vecs[t].inc0 : 24'h000300, vecs[t].en_mask[v]);
            end
            wave_mode = vecs[t].mode;
            run_frame(-1, '0, 1'b0, gm, gp);
            check($sformatf("vec%0d_mix", t), 32'(gm), 32'(vecs[t].exp_mix));
            check($sformatf("vec%0d_acc0", t), 32'(dut.u_bank.acc_q[0]), 32'(vecs[t].exp_acc0));
        end

        // Voice 0 ramp: phases 0,1,2 and acc0 = 0x600
        do_reset();
        cfg_write(0, 24'h000200, 1'b1);
        wave_mode = 0;
        for (int k = 0; k < 3; k++) begin
            run_frame(-1, '0, 1'b0, gm, gp);
            check($sformatf("ramp_ph0_%0d", k), 32'(gp), 32'(k));
        end
        check("ramp_acc0", 32'(dut.u_bank.acc_q[0]), 32'h000600);

        // Full-scale sum and accumulator wrap
        do_reset();
        cfg_write(0, 24'hFFFE00, 1'b1);
        for (int v = 1; v < N; v++) cfg_write(v, 24'h000400, 1'b1);
        wave_mode = 1;
        run_frame(-1, '0, 1'b0, gm, gp);
        check("full_mix_a", 32'(gm), 32'h3FFC);
        check("wrap_pre_acc0", 32'(dut.u_bank.acc_q[0]), 32'hFFFE00);
        cfg_write(0, 24'h000400, 1'b1);
        run_frame(-1, '0, 1'b0, gm, gp);
        check("full_mix_b", 32'(gm), 32'h3FFC);
        check("wrap_ph0", 32'(gp), 32'h7FFF);
        check("wrap_acc0", 32'(dut.u_bank.acc_q[0]), 32'h000200);

        // Back-pressure in HOLD with a tick arriving
        do_reset();
        for (int v = 0; v < N; v++) cfg_write(v, 24'(32'h100 * (v + 1)), 1'b1);
        run_frame(-1, '0, 1'b0, gm, gp);
        wave_mode = 2;
        x0 = xfer_cnt;
        mix_ready = 1'b0;
        run_frame(-1, '0, 1'b0, gm, gp);
        hold = mix_data;
        for (int i = 0; i < 5; i++) begin
            sample_tick = (i == 1);
            @(negedge clk);
            check($sformatf("hold_valid_%0d", i), 32'(mix_valid), 32'h1);
            check($sformatf("hold_data_%0d", i), 32'(mix_data), 32'(hold));
        end
        sample_tick = 1'b0;
        mix_ready = 1'b1;
        @(negedge clk);
        check("hold_release_valid", 32'(mix_valid), 32'h0);
        repeat (8) @(negedge clk);
        check("hold_no_restart", 32'(busy), 32'h0);
        check("hold_single_xfer", 32'(xfer_cnt - x0), 32'h1);
`ifdef SAWTOOTH_SCHED_OVERRUN_EN
        check("overrun_cnt", 32'(overrun_cnt), 32'h1);
`endif

        // cfg write to voice 2 on its issue cycle
        do_reset();
        cfg_write(2, 24'h000200, 1'b1);
        wave_mode = 0;
        run_frame(2, 24'h001000, 1'b1, gm, gp);
        check("samecyc_acc2_a", 32'(dut.u_bank.acc_q[2]), 32'h000200);
        run_frame(-1, '0, 1'b0, gm, gp);
        check("samecyc_acc2_b", 32'(dut.u_bank.acc_q[2]), 32'h001200);

        // Reset during DRAIN abandons the frame
        do_reset();
        for (int v = 0; v < N; v++) cfg_write(v, 24'h012345, 1'b1);
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        repeat (N) @(negedge clk);
        check("drain_busy", 32'(busy), 32'h1);
        x0 = xfer_cnt;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("drain_rst_busy", 32'(busy), 32'h0);
        check("drain_rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("drain_rst_mix", 32'(mix_data), 32'h0);
        check_regs_zero("drain_rst");
        begin
            int seen = 0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (mix_valid) seen++;
            end
            check("drain_rst_no_valid", 32'(seen), 32'h0);
        end

        // Randomized frames against the reference model
        do_reset();
        for (int f = 0; f < 40; f++) begin
            int nw, inj;
            nw = $urandom_range(0, 2);
            for (int k = 0; k < nw; k++) begin
                cfg_write($urandom_range(0, N - 1), 24'($urandom), ($urandom_range(0, 3) != 0));
            end
            wave_mode = $urandom_range(0, 2);
            inj = ($urandom_range(0, 3) == 0) ? $urandom_range(0, N - 1) : -1;
            run_frame(inj, 24'($urandom), 1'($urandom_range(0, 1)), gm, gp);
        end
        for (int i = 0; i < N; i++) begin
            check($sformatf("rand_acc%0d", i), 32'(dut.u_bank.acc_q[i]), 32'(m_acc[i]));
        end
`ifdef SAWTOOTH_SCHED_OVERRUN_EN
        check("rand_overrun", 32'(overrun_cnt), 32'(m_ovr));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
